design_4x4_noc: RTL and testbench
=================================

# design_4x4_noc

Two-initiator AXI4-Lite memory fabric that models the 4x4 NoC mesh with its AXI network adapters as a fixed-latency network. Two AXI4-Lite slave ports connect the master network adapters MNA_0 (node 0,0) and MNA_1 (node 3,3). Two 16-word register memories sit at the target nodes: memory 0 at node (3,0) and memory 1 at node (0,3). Either master can read and write either memory. The block is the system top used for end-to-end write-then-read checks across the network.

## Interface
- NET_LAT, 6, one-way network latency in cycles (request or response traversal); legal values are 1 to 15.
- clk_0  in  1  system clock; all logic is on the rising edge.
- rst_0  in  1  synchronous, active-high reset.
- sN_awaddr, sN_araddr  in  32  write and read addresses, where N is 0 or 1.
- sN_awprot, sN_arprot  in  3  protection bits; these are accepted and ignored.
- sN_awvalid, sN_wvalid, sN_bready, sN_arvalid, sN_rready  in  1  AXI4-Lite handshake inputs.
- sN_awready, sN_wready, sN_bvalid, sN_arready, sN_rvalid  out  1  AXI4-Lite handshake outputs.
- sN_wdata  in  32  write data.
- sN_wstrb  in  4  byte-lane write strobes.
- sN_bresp, sN_rresp  out  2  responses: OKAY is 2'b00 and DECERR is 2'b11.
- sN_rdata  out  32  read data.

## Operation
- Address decode:
  - addr[31] selects the target: 0 selects memory 0 (0x7xxx_xxxx) and 1 selects memory 1 (0xFxxx_xxxx).
  - addr[5:2] is the word index.
  - addr[1:0] and addr[27:6] are ignored, so addresses alias.
- Each memory holds 16 words of 32 bits each. All words clear to 0 on reset.
- Writes honour wstrb per byte.
- Each port allows at most one outstanding write and one outstanding read. A write and a read on the same port may overlap.
- Write accept:
  - sN_awready and sN_wready pulse high together for one cycle.
  - They pulse only when sN_awvalid and sN_wvalid are both high and the port has no write outstanding.
- Read accept: sN_arready pulses high for one cycle when sN_arvalid is high and the port has no read outstanding.
- Each memory performs at most one access per cycle.
- If requests from both ports arrive at the same memory in the same cycle:
  - A round-robin arbiter picks one; after reset it favours port 0.
  - The losing request is served in the next cycle.
  - The winner's priority moves to the other port.
- When a write and a read to the same word arrive at the same memory in the same cycle, the one that wins arbitration executes first. If it is the same port, the write goes first.
- The response holds in bvalid/rvalid until the matching ready is seen. After that handshake the port may accept a new transaction.

## Timing
- Reset values:
  - All ready and valid outputs are 0.
  - sN_bresp, sN_rresp and sN_rdata are 0.
  - The arbiter favours port 0.
  - Any in-flight transactions are discarded.
- An asserted rst_0 aborts any transaction in flight. No response is issued for it.
- Accept handshake at cycle T: the request reaches the memory at T+NET_LAT, and the memory access happens in that cycle.
- Uncontended response: bvalid or rvalid rises at T+2*NET_LAT+1, which is T+13 at the default NET_LAT.
- Each cycle lost in arbitration adds one cycle to the response.
- rdata and rresp are valid while rvalid is high and stay stable until rready.
- After the B or R handshake at cycle H, the earliest next accept on that channel is H+1.
- A ready pulse never occurs in a cycle in which rst_0 is high.

## Configuration
- DECERR_EN, defined:
  - A request whose addr[30:28] is not 3'b111 writes nothing.
  - Such a write returns bresp 2'b11.
  - Such a read returns rresp 2'b11 with rdata 0.
  - Latency is the same as for a normal access.
- DECERR_EN, undefined: addr[30:28] is ignored, and every response is OKAY (2'b00).

## Test plan
- Write then read across ports:
  - Stimulus: after reset, port 0 writes 0x11000011 to 0x70000000, 0x22000022 to 0x70000004 and 0x33000033 to 0x70000008, all with wstrb 4'hF. Port 1 then reads the same three addresses.
  - Response: reads return 0x11000011, 0x22000022 and 0x33000033. Every bresp and rresp is 2'b00.
- Latency:
  - Stimulus: a single write accepted at cycle T with NET_LAT=6 and bready held high.
  - Response: bvalid is high only at cycle T+13.
- Contention:
  - Stimulus: port 0 writes 0x11111111 and port 1 writes 0x22111122 to 0xF0000000, both accepted in the same cycle right after reset. Then 0xF0000000 is read.
  - Response: port 1's bvalid arrives one cycle after port 0's. The read returns 0x22111122.
- Byte strobes:
  - Stimulus: write 0xAABBCCDD to 0x70000000, then write 0x00000000 with wstrb 4'b0101.
  - Response: a read returns 0xAA00CC00.
- Decode error (DECERR_EN defined):
  - Stimulus: write to 0x00000000, then read 0x00000000.
  - Response: bresp is 2'b11, rresp is 2'b11 and rdata is 0. Memory 0 word 0 is unchanged.
- Reset mid-operation:
  - Stimulus: assert rst_0 for one cycle 4 cycles after a write accept.
  - Response: no bvalid follows, all memory words read back 0, and a new write is accepted normally.

Source files
------------

// File: rtl/design_4x4_noc.sv
// Two-initiator AXI4-Lite fabric modelling the 4x4 NoC as a fixed-latency network to two 16-word memories.
// Optional macro DECERR_EN: addresses with addr[30:28] != 3'b111 return DECERR and do not touch memory.
module design_4x4_noc #(
  parameter int NET_LAT = 6
) (
  input  logic        clk_0,
  input  logic        rst_0,
  input  logic [31:0] s0_awaddr,
  input  logic [2:0]  s0_awprot,
  input  logic        s0_awvalid,
  output logic        s0_awready,
  input  logic [31:0] s0_wdata,
  input  logic [3:0]  s0_wstrb,
  input  logic        s0_wvalid,
  output logic        s0_wready,
  output logic [1:0]  s0_bresp,
  output logic        s0_bvalid,
  input  logic        s0_bready,
  input  logic [31:0] s0_araddr,
  input  logic [2:0]  s0_arprot,
  input  logic        s0_arvalid,
  output logic        s0_arready,
  output logic [31:0] s0_rdata,
  output logic [1:0]  s0_rresp,
  output logic        s0_rvalid,
  input  logic        s0_rready,
  input  logic [31:0] s1_awaddr,
  input  logic [2:0]  s1_awprot,
  input  logic        s1_awvalid,
  output logic        s1_awready,
  input  logic [31:0] s1_wdata,
  input  logic [3:0]  s1_wstrb,
  input  logic        s1_wvalid,
  output logic        s1_wready,
  output logic [1:0]  s1_bresp,
  output logic        s1_bvalid,
  input  logic        s1_bready,
  input  logic [31:0] s1_araddr,
  input  logic [2:0]  s1_arprot,
  input  logic        s1_arvalid,
  output logic        s1_arready,
  output logic [31:0] s1_rdata,
  output logic [1:0]  s1_rresp,
  output logic        s1_rvalid,
  input  logic        s1_rready
);

  typedef struct packed {
    logic        mem;
    logic [3:0]  idx;
    logic [31:0] data;
    logic [3:0]  strb;
    logic        derr;
  } req_t;

  typedef struct packed {
    logic [1:0]  resp;
    logic [31:0] data;
  } rsp_t;

  // Channel index: {port, is_read}
  logic [1:0]         wr_acc, rd_acc, wr_busy, rd_busy, aw_derr, ar_derr;
  logic [1:0]         bready, rready, bvalid_q, rvalid_q;
  logic [1:0]         bresp_q [2];
  logic [1:0]         rresp_q [2];
  logic [31:0]        rdata_q [2];
  logic [3:0]         in_vld, hold_vld_p1, cur_vld, gnt;
  req_t               in_req [4];
  req_t               cur_req [4];
  req_t               hold_dat_p1 [4];
  logic [NET_LAT-1:0] req_vld_p0 [4];
  req_t               req_dat_p0 [4][NET_LAT];
  logic [NET_LAT-1:0] rsp_vld_p2 [4];
  rsp_t               rsp_dat_p2 [4][NET_LAT];
  rsp_t               rsp_in [4];
  logic [1:0]         rr, win_vld, win_port;
  logic [31:0]        mem [2][16];
  logic               unused_bits;

`ifdef DECERR_EN
  assign aw_derr = {s1_awaddr[30:28] != 3'b111, s0_awaddr[30:28] != 3'b111};
  assign ar_derr = {s1_araddr[30:28] != 3'b111, s0_araddr[30:28] != 3'b111};
`else
  assign aw_derr = 2'b00;
  assign ar_derr = 2'b00;
`endif

  assign unused_bits = ^{s0_awaddr[30:6], s0_awaddr[1:0], s0_araddr[30:6], s0_araddr[1:0],
                         s1_awaddr[30:6], s1_awaddr[1:0], s1_araddr[30:6], s1_araddr[1:0],
                         s0_awprot, s0_arprot, s1_awprot, s1_arprot};

  assign wr_acc[0] = !rst_0 && s0_awvalid && s0_wvalid && !wr_busy[0];
  assign wr_acc[1] = !rst_0 && s1_awvalid && s1_wvalid && !wr_busy[1];
  assign rd_acc[0] = !rst_0 && s0_arvalid && !rd_busy[0];
  assign rd_acc[1] = !rst_0 && s1_arvalid && !rd_busy[1];
  assign bready    = {s1_bready, s0_bready};
  assign rready    = {s1_rready, s0_rready};

  assign s0_awready = wr_acc[0];
  assign s0_wready  = wr_acc[0];
  assign s0_arready = rd_acc[0];
  assign s1_awready = wr_acc[1];
  assign s1_wready  = wr_acc[1];
  assign s1_arready = rd_acc[1];
  assign s0_bvalid  = bvalid_q[0];
  assign s0_bresp   = bresp_q[0];
  assign s0_rvalid  = rvalid_q[0];
  assign s0_rresp   = rresp_q[0];
  assign s0_rdata   = rdata_q[0];
  assign s1_bvalid  = bvalid_q[1];
  assign s1_bresp   = bresp_q[1];
  assign s1_rvalid  = rvalid_q[1];
  assign s1_rresp   = rresp_q[1];
  assign s1_rdata   = rdata_q[1];

  always_comb begin
    in_vld    = {rd_acc[1], wr_acc[1], rd_acc[0], wr_acc[0]};
    in_req[0] = '{mem: s0_awaddr[31], idx: s0_awaddr[5:2], data: s0_wdata, strb: s0_wstrb, derr: aw_derr[0]};
    in_req[1] = '{mem: s0_araddr[31], idx: s0_araddr[5:2], data: 32'h0, strb: 4'h0, derr: ar_derr[0]};
    in_req[2] = '{mem: s1_awaddr[31], idx: s1_awaddr[5:2], data: s1_wdata, strb: s1_wstrb, derr: aw_derr[1]};
    in_req[3] = '{mem: s1_araddr[31], idx: s1_araddr[5:2], data: 32'h0, strb: 4'h0, derr: ar_derr[1]};
  end

  // Stage p0: request traversal through the network
  always_ff @(posedge clk_0) begin
    for (int ch = 0; ch < 4; ch++) begin
      if (rst_0) req_vld_p0[ch] <= '0;
      else       req_vld_p0[ch] <= (req_vld_p0[ch] << 1) | NET_LAT'(in_vld[ch]);
    end
  end

  always_ff @(posedge clk_0) begin
    for (int ch = 0; ch < 4; ch++) begin
      req_dat_p0[ch][0] <= in_req[ch];
      for (int i = 1; i < NET_LAT; i++) req_dat_p0[ch][i] <= req_dat_p0[ch][i-1];
    end
  end

  // A held (arbitration-losing) request and a fresh arrival never coexist on one channel
  always_comb begin
    for (int ch = 0; ch < 4; ch++) begin
      cur_vld[ch] = hold_vld_p1[ch] | req_vld_p0[ch][NET_LAT-1];
      cur_req[ch] = hold_vld_p1[ch] ? hold_dat_p1[ch] : req_dat_p0[ch][NET_LAT-1];
    end
  end

  // Favoured port first; within a port the write goes before the read
  always_comb begin
    logic       port;
    logic [1:0] ch;
    gnt      = '0;
    win_vld  = '0;
    win_port = '0;
    for (int m = 0; m < 2; m++) begin
      for (int k = 0; k < 4; k++) begin
        port = (k < 2) ? rr[m] : !rr[m];
        ch   = {port, k[0]};
        if (!win_vld[m] && cur_vld[ch] && (cur_req[ch].mem == m[0])) begin
          gnt[ch]     = 1'b1;
          win_vld[m]  = 1'b1;
          win_port[m] = port;
        end
      end
    end
  end

  // Stage p1: arbitration hold and round-robin state
  always_ff @(posedge clk_0) begin
    if (rst_0) begin
      hold_vld_p1 <= '0;
      rr          <= '0;
    end else begin
      hold_vld_p1 <= cur_vld & ~gnt;
      for (int m = 0; m < 2; m++)
        if (win_vld[m]) rr[m] <= !win_port[m];
    end
  end

  always_ff @(posedge clk_0) begin
    for (int ch = 0; ch < 4; ch++) hold_dat_p1[ch] <= cur_req[ch];
  end

  always_ff @(posedge clk_0) begin
    if (rst_0) begin
      for (int m = 0; m < 2; m++)
        for (int w = 0; w < 16; w++) mem[m][w] <= '0;
    end else begin
      for (int ch = 0; ch < 4; ch++)
        if (gnt[ch] && !ch[0] && !cur_req[ch].derr)
          for (int b = 0; b < 4; b++)
            if (cur_req[ch].strb[b])
              mem[cur_req[ch].mem][cur_req[ch].idx][8*b +: 8] <= cur_req[ch].data[8*b +: 8];
    end
  end

  always_comb begin
    for (int ch = 0; ch < 4; ch++) begin
      rsp_in[ch].resp = cur_req[ch].derr ? 2'b11 : 2'b00;
      rsp_in[ch].data = (ch[0] && !cur_req[ch].derr) ? mem[cur_req[ch].mem][cur_req[ch].idx] : 32'h0;
    end
  end

  // Stage p2: response traversal through the network
  always_ff @(posedge clk_0) begin
    for (int ch = 0; ch < 4; ch++) begin
      if (rst_0) rsp_vld_p2[ch] <= '0;
      else       rsp_vld_p2[ch] <= (rsp_vld_p2[ch] << 1) | NET_LAT'(gnt[ch]);
    end
  end

  always_ff @(posedge clk_0) begin
    for (int ch = 0; ch < 4; ch++) begin
      rsp_dat_p2[ch][0] <= rsp_in[ch];
      for (int i = 1; i < NET_LAT; i++) rsp_dat_p2[ch][i] <= rsp_dat_p2[ch][i-1];
    end
  end

  always_ff @(posedge clk_0) begin
    if (rst_0) begin
      wr_busy  <= '0;
      rd_busy  <= '0;
      bvalid_q <= '0;
      rvalid_q <= '0;
      for (int p = 0; p < 2; p++) begin
        bresp_q[p] <= '0;
        rresp_q[p] <= '0;
        rdata_q[p] <= '0;
      end
    end else begin
      for (int p = 0; p < 2; p++) begin
        if (wr_acc[p])                       wr_busy[p] <= 1'b1;
        else if (bvalid_q[p] && bready[p])   wr_busy[p] <= 1'b0;
        if (rd_acc[p])                       rd_busy[p] <= 1'b1;
        else if (rvalid_q[p] && rready[p])   rd_busy[p] <= 1'b0;
        if (rsp_vld_p2[2*p][NET_LAT-1]) begin
          bvalid_q[p] <= 1'b1;
          bresp_q[p]  <= rsp_dat_p2[2*p][NET_LAT-1].resp;
        end else if (bvalid_q[p] && bready[p]) begin
          bvalid_q[p] <= 1'b0;
        end
        if (rsp_vld_p2[2*p+1][NET_LAT-1]) begin
          rvalid_q[p] <= 1'b1;
          rresp_q[p]  <= rsp_dat_p2[2*p+1][NET_LAT-1].resp;
          rdata_q[p]  <= rsp_dat_p2[2*p+1][NET_LAT-1].data;
        end else if (rvalid_q[p] && rready[p]) begin
          rvalid_q[p] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_design_4x4_noc.sv
// Directed testbench for design_4x4_noc: cross-port write/read, latency, contention, strobes, decode, reset.
module tb_design_4x4_noc;

  logic        clk_0 = 1'b0;
  logic        rst_0;
  logic [31:0] s0_awaddr, s0_wdata, s0_araddr, s0_rdata;
  logic [31:0] s1_awaddr, s1_wdata, s1_araddr, s1_rdata;
  logic [2:0]  s0_awprot, s0_arprot, s1_awprot, s1_arprot;
  logic [3:0]  s0_wstrb, s1_wstrb;
  logic        s0_awvalid, s0_awready, s0_wvalid, s0_wready, s0_bvalid, s0_bready;
  logic        s0_arvalid, s0_arready, s0_rvalid, s0_rready;
  logic        s1_awvalid, s1_awready, s1_wvalid, s1_wready, s1_bvalid, s1_bready;
  logic        s1_arvalid, s1_arready, s1_rvalid, s1_rready;
  logic [1:0]  s0_bresp, s0_rresp, s1_bresp, s1_rresp;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always #5 clk_0 = ~clk_0;
  always @(posedge clk_0) cyc <= cyc + 1;

  design_4x4_noc #(.NET_LAT(6)) dut (
    .clk_0(clk_0), .rst_0(rst_0),
    .s0_awaddr(s0_awaddr), .s0_awprot(s0_awprot), .s0_awvalid(s0_awvalid), .s0_awready(s0_awready),
    .s0_wdata(s0_wdata), .s0_wstrb(s0_wstrb), .s0_wvalid(s0_wvalid), .s0_wready(s0_wready),
    .s0_bresp(s0_bresp), .s0_bvalid(s0_bvalid), .s0_bready(s0_bready),
    .s0_araddr(s0_araddr), .s0_arprot(s0_arprot), .s0_arvalid(s0_arvalid), .s0_arready(s0_arready),
    .s0_rdata(s0_rdata), .s0_rresp(s0_rresp), .s0_rvalid(s0_rvalid), .s0_rready(s0_rready),
    .s1_awaddr(s1_awaddr), .s1_awprot(s1_awprot), .s1_awvalid(s1_awvalid), .s1_awready(s1_awready),
    .s1_wdata(s1_wdata), .s1_wstrb(s1_wstrb), .s1_wvalid(s1_wvalid), .s1_wready(s1_wready),
    .s1_bresp(s1_bresp), .s1_bvalid(s1_bvalid), .s1_bready(s1_bready),
    .s1_araddr(s1_araddr), .s1_arprot(s1_arprot), .s1_arvalid(s1_arvalid), .s1_arready(s1_arready),
    .s1_rdata(s1_rdata), .s1_rresp(s1_rresp), .s1_rvalid(s1_rvalid), .s1_rready(s1_rready)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive_aw(input int p, input logic v, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s);
    if (p == 0) begin
      s0_awvalid = v; s0_wvalid = v; s0_awaddr = a; s0_wdata = d; s0_wstrb = s;
    end else begin
      s1_awvalid = v; s1_wvalid = v; s1_awaddr = a; s1_wdata = d; s1_wstrb = s;
    end
  endtask

  task automatic drive_ar(input int p, input logic v, input logic [31:0] a);
    if (p == 0) begin s0_arvalid = v; s0_araddr = a; end
    else        begin s1_arvalid = v; s1_araddr = a; end
  endtask

  task automatic do_write(input int p, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          output int acc, output int bc, output logic [1:0] resp);
    logic rdy;
    acc  = -1;
    bc   = -1;
    resp = 2'bxx;
    drive_aw(p, 1'b1, a, d, s);
    for (int i = 0; i < 40; i++) begin
      #1;
      rdy = (p == 0) ? (s0_awready && s0_wready) : (s1_awready && s1_wready);
      if (rdy) begin acc = cyc; break; end
      @(negedge clk_0);
    end
    @(negedge clk_0);
    drive_aw(p, 1'b0, a, d, s);
    for (int i = 0; i < 60; i++) begin
      if ((p == 0) ? s0_bvalid : s1_bvalid) begin
        bc   = cyc;
        resp = (p == 0) ? s0_bresp : s1_bresp;
        break;
      end
      @(negedge clk_0);
    end
    @(negedge clk_0);
  endtask

  task automatic do_read(input int p, input logic [31:0] a,
                         output int acc, output int rc, output logic [31:0] data, output logic [1:0] resp);
    acc  = -1;
    rc   = -1;
    data = 'x;
    resp = 2'bxx;
    drive_ar(p, 1'b1, a);
    for (int i = 0; i < 40; i++) begin
      #1;
      if ((p == 0) ? s0_arready : s1_arready) begin acc = cyc; break; end
      @(negedge clk_0);
    end
    @(negedge clk_0);
    drive_ar(p, 1'b0, a);
    for (int i = 0; i < 60; i++) begin
      if ((p == 0) ? s0_rvalid : s1_rvalid) begin
        rc   = cyc;
        data = (p == 0) ? s0_rdata : s1_rdata;
        resp = (p == 0) ? s0_rresp : s1_rresp;
        break;
      end
      @(negedge clk_0);
    end
    @(negedge clk_0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          a0, a1, b0, b1, r0c;
    logic [1:0]  rs0, rs1;
    logic [31:0] rd;
    int          nb;

    rst_0 = 1'b1;
    drive_aw(0, 1'b0, 32'h0, 32'h0, 4'h0);
    drive_aw(1, 1'b0, 32'h0, 32'h0, 4'h0);
    drive_ar(0, 1'b0, 32'h0);
    drive_ar(1, 1'b0, 32'h0);
    s0_awprot = 3'b0; s0_arprot = 3'b0; s1_awprot = 3'b0; s1_arprot = 3'b0;
    s0_bready = 1'b1; s0_rready = 1'b1; s1_bready = 1'b1; s1_rready = 1'b1;

    // Ready must stay low while reset is asserted
    repeat (2) @(negedge clk_0);
    drive_aw(0, 1'b1, 32'h70000000, 32'hDEADBEEF, 4'hF);
    drive_ar(1, 1'b1, 32'h70000000);
    #1;
    check("rst_awready", {31'h0, s0_awready}, 32'h0);
    check("rst_arready", {31'h0, s1_arready}, 32'h0);
    drive_aw(0, 1'b0, 32'h0, 32'h0, 4'h0);
    drive_ar(1, 1'b0, 32'h0);
    @(negedge clk_0);
    rst_0 = 1'b0;
    #1;
    check("rst_valids", {28'h0, s0_bvalid, s0_rvalid, s1_bvalid, s1_rvalid}, 32'h0);
    check("rst_resps", {24'h0, s0_bresp, s0_rresp, s1_bresp, s1_rresp}, 32'h0);
    check("rst_rdata0", s0_rdata, 32'h0);
    check("rst_rdata1", s1_rdata, 32'h0);
    @(negedge clk_0);

    // Contention on memory 1 right after reset: port 0 wins, port 1 one cycle later
    fork
      do_write(0, 32'hF0000000, 32'h11111111, 4'hF, a0, b0, rs0);
      do_write(1, 32'hF0000000, 32'h22111122, 4'hF, a1, b1, rs1);
    join
    check("cont_same_acc", a1 - a0, 32'd0);
    check("cont_lat0", b0 - a0, 32'd13);
    check("cont_lat1", b1 - a0, 32'd14);
    check("cont_bresp", {30'h0, rs0 | rs1}, 32'h0);
    do_read(0, 32'hF0000000, a0, r0c, rd, rs0);
    check("cont_rdata", rd, 32'h22111122);
    check("rd_lat", r0c - a0, 32'd13);

    // Write on port 0, read back on port 1
    do_write(0, 32'h70000000, 32'h11000011, 4'hF, a0, b0, rs0);
    check("wr_lat", b0 - a0, 32'd13);
    check("wr_bresp0", {30'h0, rs0}, 32'h0);
    do_write(0, 32'h70000004, 32'h22000022, 4'hF, a1, b1, rs1);
    check("b2b_accept", a1 - b0, 32'd1);
    check("wr_bresp1", {30'h0, rs1}, 32'h0);
    do_write(0, 32'h70000008, 32'h33000033, 4'hF, a0, b0, rs0);
    check("wr_bresp2", {30'h0, rs0}, 32'h0);
    do_read(1, 32'h70000000, a0, r0c, rd, rs0);
    check("xrd0", rd, 32'h11000011);
    check("xrd0_resp", {30'h0, rs0}, 32'h0);
    do_read(1, 32'h70000004, a0, r0c, rd, rs0);
    check("xrd1", rd, 32'h22000022);
    do_read(1, 32'h70000008, a0, r0c, rd, rs0);
    check("xrd2", rd, 32'h33000033);
    check("xrd2_resp", {30'h0, rs0}, 32'h0);

    // Same port, write and read of the same word together: write executes first
    fork
      do_write(0, 32'h7000003C, 32'h0BADBEEF, 4'hF, a0, b0, rs0);
      do_read(0, 32'h7000003C, a1, r0c, rd, rs1);
    join
    check("wr_rd_same_acc", a1 - a0, 32'd0);
    check("wr_rd_order", r0c - b0, 32'd1);
    check("wr_rd_data", rd, 32'h0BADBEEF);

    // Byte strobes
    do_write(1, 32'h70000000, 32'hAABBCCDD, 4'hF, a0, b0, rs0);
    do_write(1, 32'h70000000, 32'h00000000, 4'b0101, a0, b0, rs0);
    do_read(0, 32'h70000000, a0, r0c, rd, rs0);
    check("strb_data", rd, 32'hAA00CC00);

    // Address 0x00000000: decode error when enabled, alias of memory 0 otherwise
    do_write(0, 32'h00000000, 32'h5A5A5A5A, 4'hF, a0, b0, rs0);
    check("dec_wr_lat", b0 - a0, 32'd13);
`ifdef DECERR_EN
    check("dec_bresp", {30'h0, rs0}, 32'h3);
    do_read(0, 32'h00000000, a0, r0c, rd, rs0);
    check("dec_rresp", {30'h0, rs0}, 32'h3);
    check("dec_rdata", rd, 32'h0);
    check("dec_rd_lat", r0c - a0, 32'd13);
    do_read(1, 32'h70000000, a0, r0c, rd, rs0);
    check("dec_mem_kept", rd, 32'hAA00CC00);
`else
    check("alias_bresp", {30'h0, rs0}, 32'h0);
    do_read(0, 32'h00000000, a0, r0c, rd, rs0);
    check("alias_rresp", {30'h0, rs0}, 32'h0);
    check("alias_rdata", rd, 32'h5A5A5A5A);
    do_read(1, 32'h70000000, a0, r0c, rd, rs0);
    check("alias_mem0", rd, 32'h5A5A5A5A);
`endif

    // Reset four cycles after a write accept discards it and clears the memories
    drive_aw(0, 1'b1, 32'h70000004, 32'h12345678, 4'hF);
    a0 = -1;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (s0_awready) begin a0 = cyc; break; end
      @(negedge clk_0);
    end
    check("rst_mid_accept", {31'h0, (a0 >= 0)}, 32'h1);
    @(negedge clk_0);
    drive_aw(0, 1'b0, 32'h0, 32'h0, 4'h0);
    repeat (3) @(negedge clk_0);
    rst_0 = 1'b1;
    @(negedge clk_0);
    rst_0 = 1'b0;
    nb = 0;
    for (int i = 0; i < 30; i++) begin
      if (s0_bvalid) nb++;
      @(negedge clk_0);
    end
    check("rst_no_bvalid", nb, 32'd0);
    for (int w = 0; w < 16; w++) begin
      do_read(1, 32'h70000000 + 32'(4 * w), a0, r0c, rd, rs0);
      check($sformatf("rst_mem0_w%0d", w), rd, 32'h0);
      do_read(0, 32'hF0000000 + 32'(4 * w), a0, r0c, rd, rs0);
      check($sformatf("rst_mem1_w%0d", w), rd, 32'h0);
    end
    do_write(0, 32'h70000010, 32'hCAFEF00D, 4'hF, a0, b0, rs0);
    check("post_rst_lat", b0 - a0, 32'd13);
    check("post_rst_bresp", {30'h0, rs0}, 32'h0);
    do_read(1, 32'h70000010, a0, r0c, rd, rs0);
    check("post_rst_rdata", rd, 32'hCAFEF00D);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
